spi_adc_reader: RTL and testbench

- SPI master that reads the scope's two-channel 12-bit serial ADC.
- Generates sclk/cs_n, shifts the channel address out on mosi and shifts the conversion result in on miso.
- Alternates channel 0/1 each frame and presents truncated DATA_W-bit samples with a one-cycle valid strobe to the capture/trigger logic.
- Complement of the DAC write path: same SPI mode, same 16-bit frame, opposite data direction.

---
 rtl/spi_adc_pkg.sv | 37 +++
 rtl/spi_half_tick.sv | 30 +++
 rtl/spi_adc_reader.sv | 161 ++++++++++++++++
 tb/tb_spi_adc_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the two-channel 12-bit serial ADC reader.
//   state_t    : FSM states of spi_adc_reader
//   FRAME_BITS : SPI frame length (16 sclk cycles)
//   LEAD_BITS  : leading frame bits ahead of the conversion result
//   ADC_BITS   : conversion result width
//   CH0_ADDR / CH1_ADDR : channel address sent in frame bits 2..4
//   frame_bit() : control bit driven on mosi for a given channel and bit index
package spi_adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_t;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LEAD_BITS  = 4;
  localparam int unsigned ADC_BITS   = 12;

  localparam int unsigned ADDR_W = 3;
  localparam logic [ADDR_W-1:0] CH0_ADDR = 3'b000;
  localparam logic [ADDR_W-1:0] CH1_ADDR = 3'b001;

  // Frame bit k (MSB first): address MSB..LSB sit at k = 2, 3, 4; all else 0.
  function automatic logic frame_bit(input logic ch, input logic [3:0] k);
    logic [ADDR_W-1:0] addr;
    addr = ch ? CH1_ADDR : CH0_ADDR;
    case (k)
      4'd2:    frame_bit = addr[2];
      4'd3:    frame_bit = addr[1];
      4'd4:    frame_bit = addr[0];
      default: frame_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timebase for the SPI master.
// Counts 0..HALF_DIV-1 and raises tick during the terminal count.
//   clk     : system clock
//   reset   : synchronous, active-high
//   restart : force the count back to 0 (asserted on FSM state changes)
//   tick    : high for one clk at the end of every half-period
module spi_half_tick #(
  parameter int unsigned HALF_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(HALF_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (reset || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/spi_adc_reader.sv
// SPI master reading a two-channel 12-bit serial ADC (CPOL=1, CPHA=1,
// 16-bit frames). Channels alternate ch0, ch1, ch0, ... every frame; the top
// DATA_W bits of each 12-bit result are published with a one-clk valid pulse.
//   clk, reset   : system clock, synchronous active-high reset
//   enable       : level; frames run back-to-back while high (sampled in IDLE)
//   miso         : ADC serial data
//   sclk, cs_n   : SPI clock (idles high) and active-low chip select
//   mosi         : channel-address control bits
//   sample_1/2   : last ch0 / ch1 sample
//   sample_valid : one-clk pulse when a sample register updates
//   sample_ch    : channel of the last published sample
//   busy         : high whenever the FSM is not in IDLE
// Optional build macro SPI_ADC_FRAME_CHECK_EN adds frame_err, high in the
// sample_valid cycle when any of the 4 leading captured bits was nonzero.
module spi_adc_reader
  import spi_adc_pkg::*;
#(
  parameter int unsigned HALF_DIV = 25,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              miso,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] sample_1,
  output logic [DATA_W-1:0] sample_2,
  output logic              sample_valid,
  output logic              sample_ch,
  output logic              busy
`ifdef SPI_ADC_FRAME_CHECK_EN
  ,
  output logic              frame_err
`endif
);

  state_t                state;
  logic                  tick;
  logic                  leave;
  logic                  ch;
  logic [3:0]            bit_cnt;
  // Only the 12 result bits are kept: the 4 leading bits shift out the top.
  logic [ADC_BITS-1:0]   shreg;
`ifdef SPI_ADC_FRAME_CHECK_EN
  logic                  lead_nz;
`endif

  spi_half_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (leave),
    .tick    (tick)
  );

  // State exit this cycle; also restarts the half-period counter.
  always_comb begin
    leave = 1'b0;
    if (tick) begin
      case (state)
        IDLE:     leave = enable;
        CS_SETUP: leave = 1'b1;
        SHIFT:    leave = !sclk && (bit_cnt == 4'(FRAME_BITS - 1));
        CS_HOLD:  leave = 1'b1;
        default:  leave = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sclk         <= 1'b1;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      sample_1     <= '0;
      sample_2     <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= 1'b0;
      busy         <= 1'b0;
      ch           <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
`ifdef SPI_ADC_FRAME_CHECK_EN
      lead_nz      <= 1'b0;
      frame_err    <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
`ifdef SPI_ADC_FRAME_CHECK_EN
      frame_err    <= 1'b0;
`endif
      if (tick) begin
        case (state)
          IDLE: begin
            if (enable) begin
              state <= CS_SETUP;
              cs_n  <= 1'b0;
              sclk  <= 1'b1;
              mosi  <= 1'b0;
              busy  <= 1'b1;
            end
          end

          CS_SETUP: begin
            state   <= SHIFT;
            bit_cnt <= '0;
`ifdef SPI_ADC_FRAME_CHECK_EN
            lead_nz <= 1'b0;
`endif
          end

          SHIFT: begin
            if (sclk) begin
              // Falling edge: present control bit for this position.
              sclk <= 1'b0;
              mosi <= frame_bit(ch, bit_cnt);
            end else begin
              // Rising edge: capture ADC data, advance bit position.
              sclk    <= 1'b1;
              shreg   <= {shreg[ADC_BITS-2:0], miso};
              bit_cnt <= bit_cnt + 4'd1;
`ifdef SPI_ADC_FRAME_CHECK_EN
              if (bit_cnt < 4'(LEAD_BITS)) begin
                lead_nz <= lead_nz | miso;
              end
`endif
              if (leave) begin
                state <= CS_HOLD;
              end
            end
          end

          CS_HOLD: begin
            state        <= IDLE;
            cs_n         <= 1'b1;
            mosi         <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b1;
            sample_ch    <= ch;
            if (ch) begin
              sample_2 <= shreg[ADC_BITS-1 -: DATA_W];
            end else begin
              sample_1 <= shreg[ADC_BITS-1 -: DATA_W];
            end
            ch <= ~ch;
`ifdef SPI_ADC_FRAME_CHECK_EN
            frame_err <= lead_nz;
`endif
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Bench for spi_adc_reader: a timeline model of the HALF_DIV=2 instance is
// compared on every clk, plus directed literal checks and a HALF_DIV=25
// timing instance.
module tb_spi_adc_reader;

  localparam int H = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       miso = 1'b0;
  logic       sclk, cs_n, mosi, sample_valid, sample_ch, busy;
  logic [7:0] sample_1, sample_2;

  logic       reset25 = 1'b1;
  logic       enable25 = 1'b0;
  logic       miso25 = 1'b0;
  logic       sclk25, cs_n25, mosi25, sample_valid25, sample_ch25, busy25;
  logic [7:0] sample_125, sample_225;
`ifdef SPI_ADC_FRAME_CHECK_EN
  logic       frame_err, frame_err25;
`endif

  spi_adc_reader #(.HALF_DIV(H), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .miso(miso),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .sample_1(sample_1), .sample_2(sample_2),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .busy(busy)
`ifdef SPI_ADC_FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  spi_adc_reader #(.HALF_DIV(25), .DATA_W(8)) dut25 (
    .clk(clk), .reset(reset25), .enable(enable25), .miso(miso25),
    .sclk(sclk25), .cs_n(cs_n25), .mosi(mosi25),
    .sample_1(sample_125), .sample_2(sample_225),
    .sample_valid(sample_valid25), .sample_ch(sample_ch25), .busy(busy25)
`ifdef SPI_ADC_FRAME_CHECK_EN
    , .frame_err(frame_err25)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC word served for each successive frame (one per cs_n fall).
  logic [15:0] words [0:7] = '{16'h0ABC, 16'h0F00, 16'h0123, 16'h0555,
                               16'hFFFF, 16'h0000, 16'h0ABC, 16'h0000};

  // ADC behaviour: next data bit (MSB first) appears after each sclk fall.
  int          adc_idx = 0;
  int          adc_bit = 15;
  logic [15:0] adc_word = '0;
  always @(negedge cs_n) begin
    adc_word = words[adc_idx];
    adc_idx++;
    adc_bit = 15;
  end
  always @(negedge sclk) begin
    if (!cs_n && adc_bit >= 0) begin
      #1;
      miso = adc_word[adc_bit];
      adc_bit--;
    end
  end

  // Bus observers: mosi frame as seen by the ADC and sclk fall count.
  logic [15:0] mosi_sr = '0;
  int          nfall = 0;
  always @(negedge cs_n) begin
    mosi_sr = '0;
    nfall = 0;
  end
  always @(posedge sclk) if (!cs_n) mosi_sr = {mosi_sr[14:0], mosi};
  always @(negedge sclk) if (!cs_n) nfall++;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Timeline model: a frame is 34 half-periods with cs_n low (setup, 32
  // shift half-periods, hold) followed by one idle half-period.
  bit          m_in_frame = 0;
  int          m_f = 0, m_idle = 0, m_frames = 0, h;
  bit          m_ch = 0;
  logic [15:0] m_word = '0, mw;
  logic        e_sclk = 1, e_cs_n = 1, e_mosi = 0, e_busy = 0;
  logic        e_valid = 0, e_sch = 0, e_ferr = 0;
  logic [7:0]  e_s1 = '0, e_s2 = '0;

  always @(posedge clk) begin
    e_valid = 0;
    e_ferr = 0;
    if (reset) begin
      m_in_frame = 0; m_idle = 0; m_ch = 0;
      e_s1 = '0; e_s2 = '0; e_sch = 0;
    end else if (!m_in_frame) begin
      if (m_idle == H - 1) begin
        m_idle = 0;
        if (enable) begin
          m_in_frame = 1;
          m_f = 0;
          m_word = words[m_frames];
          m_frames++;
        end
      end else begin
        m_idle++;
      end
    end else begin
      m_f++;
      if (m_f == 34 * H) begin
        m_in_frame = 0;
        m_idle = 0;
        e_valid = 1;
        e_sch = m_ch;
        if (m_ch) e_s2 = m_word[11:4];
        else      e_s1 = m_word[11:4];
        e_ferr = |m_word[15:12];
        m_ch = !m_ch;
      end
    end
    if (m_in_frame) begin
      h = m_f / H;
      mw = m_ch ? 16'h0800 : 16'h0000;
      e_cs_n = 0;
      e_busy = 1;
      e_sclk = !(h >= 2 && h <= 32 && (h % 2) == 0);
      e_mosi = (h >= 2) ? mw[15 - (h - 2) / 2] : 1'b0;
    end else begin
      e_cs_n = 1;
      e_sclk = 1;
      e_busy = 0;
      e_mosi = 0;
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_sclk", sclk, e_sclk);
      chk("m_cs_n", cs_n, e_cs_n);
      chk("m_mosi", mosi, e_mosi);
      chk("m_busy", busy, e_busy);
      chk("m_valid", sample_valid, e_valid);
      chk("m_sample_ch", sample_ch, e_sch);
      chk("m_sample_1", sample_1, e_s1);
      chk("m_sample_2", sample_2, e_s2);
`ifdef SPI_ADC_FRAME_CHECK_EN
      chk("m_frame_err", frame_err, e_ferr);
`endif
    end
  end

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (sample_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 400), 1);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (nfall != target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("fall_wait", (n < 400), 1);
  endtask

  task automatic wait25(input bit sel_cs, input logic val, output int n);
    n = 0;
    while (((sel_cs ? cs_n25 : sclk25) !== val) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n, t1, t2, pulses;

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    cmp_on = 1;
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sample_1", sample_1, 8'h00);

    // Frame 1: ch0, ADC 0x0ABC.
    reset = 0;
    enable = 1;
    wait_valid("f1_timeout", n);
    t1 = cyc;
    chk("f1_sample_1", sample_1, 8'hAB);
    chk("f1_ch", sample_ch, 0);
    chk("f1_mosi", mosi_sr, 16'h0000);
    chk("f1_falls", nfall, 16);
`ifdef SPI_ADC_FRAME_CHECK_EN
    chk("f1_ferr", frame_err, 0);
`endif
    @(negedge clk);
    chk("f1_pulse", sample_valid, 0);

    // Frame 2: ch1, ADC 0x0F00.
    wait_valid("f2_timeout", n);
    t2 = cyc;
    chk("f2_span", t2 - t1, 70);
    chk("f2_sample_2", sample_2, 8'hF0);
    chk("f2_ch", sample_ch, 1);
    chk("f2_mosi", mosi_sr, 16'h0800);
    chk("f2_sample_1", sample_1, 8'hAB);
    @(negedge clk);

    // Frame 3: enable dropped while bit 7 is on the bus.
    wait_falls(8);
    enable = 0;
    wait_valid("f3_timeout", n);
    chk("f3_sample_1", sample_1, 8'h12);
    chk("f3_ch", sample_ch, 0);
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (sample_valid) pulses++;
    end
    chk("f3_no_more", pulses, 0);
    chk("f3_cs_n", cs_n, 1);
    chk("f3_sclk", sclk, 1);
    chk("f3_busy", busy, 0);

    // Frame 4 (ch1) aborted by reset at bit 10.
    enable = 1;
    wait_falls(11);
    reset = 1;
    @(negedge clk);
    chk("ab_cs_n", cs_n, 1);
    chk("ab_sclk", sclk, 1);
    chk("ab_sample_1", sample_1, 8'h00);
    chk("ab_sample_2", sample_2, 8'h00);
    chk("ab_valid", sample_valid, 0);
    chk("ab_busy", busy, 0);
    reset = 0;

    // Frame 5: restarts at ch0, miso all ones.
    wait_valid("f5_timeout", n);
    chk("f5_ch", sample_ch, 0);
    chk("f5_sample_1", sample_1, 8'hFF);
    chk("f5_mosi", mosi_sr, 16'h0000);
`ifdef SPI_ADC_FRAME_CHECK_EN
    chk("f5_ferr", frame_err, 1);
`endif
    @(negedge clk);
`ifdef SPI_ADC_FRAME_CHECK_EN
    chk("f5_ferr_clr", frame_err, 0);
`endif

    // Frame 6: ch1, miso all zeros.
    wait_valid("f6_timeout", n);
    chk("f6_ch", sample_ch, 1);
    chk("f6_sample_2", sample_2, 8'h00);
    @(negedge clk);

    // Frame 7: ch0, 0x0ABC again.
    wait_valid("f7_timeout", n);
    chk("f7_sample_1", sample_1, 8'hAB);
`ifdef SPI_ADC_FRAME_CHECK_EN
    chk("f7_ferr", frame_err, 0);
`endif
    enable = 0;
    repeat (80) @(negedge clk);

    // HALF_DIV=25 timing: sclk does not fall until CS_SETUP plus the first
    // (high) SHIFT half-period have elapsed.
    reset25 = 0;
    enable25 = 1;
    wait25(1, 1'b0, n); chk("t25_idle", n, 25);
    wait25(0, 1'b0, n); chk("t25_cs_to_fall", n, 50);
    wait25(0, 1'b1, n); chk("t25_low", n, 25);
    wait25(0, 1'b0, n); chk("t25_high", n, 25);
    for (int i = 0; i < 14; i++) begin
      wait25(0, 1'b1, n);
      wait25(0, 1'b0, n);
    end
    wait25(0, 1'b1, n); chk("t25_low16", n, 25);
    wait25(1, 1'b1, n); chk("t25_hold", n, 25);
    chk("t25_valid", sample_valid25, 1);
    wait25(1, 1'b0, n); chk("t25_gap", n, 25);
    enable25 = 0;
    repeat (5) @(negedge clk);

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
